rsa_reg_bank: RTL and testbench
===============================

Name: rsa_reg_bank

Overview:
Parametrised second-generation register bank between the spireg serial slave and the RSA core.
- Operands are multi-byte, built from REG_WIDTH-wide bus registers.
- Operands are double-buffered: shadow registers are written over SPI, and active registers drive the core.
- A command FSM handles start/stop, busy/done/abort/error status, result capture and an interrupt.

Parameters:
REG_WIDTH, 8, width of one bus register.
OPERAND_WIDTH, 32, RSA operand width; must be an integer multiple of REG_WIDTH. NB = OPERAND_WIDTH/REG_WIDTH.
ADDR_WIDTH, 5, bus address width; must satisfy 4 + 5*NB <= 2**ADDR_WIDTH.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
ena  input  1  design enable; when 0, all state holds and command pulses are 0.
reg_addr  input  ADDR_WIDTH  register address from spireg.
reg_wdata  input  REG_WIDTH  write data from spireg.
reg_wvld  input  1  one-cycle write strobe from spireg.
reg_rdata  output  REG_WIDTH  combinational read data for reg_addr.
rsa_p  output  OPERAND_WIDTH  active modulus.
rsa_e  output  OPERAND_WIDTH  active exponent.
rsa_m  output  OPERAND_WIDTH  active message.
rsa_const  output  OPERAND_WIDTH  active Montgomery constant.
rsa_c  input  OPERAND_WIDTH  result from core; valid when eoc=1.
eoc  input  1  end-of-computation pulse from core.
rsa_start_cmd  output  1  one-cycle start pulse to core.
rsa_stop_cmd  output  1  one-cycle abort pulse to core.
spare  output  REG_WIDTH  spare register contents.
irq  output  1  level interrupt: irq_en & done.

Behaviour:
- Reset: all registers (shadow, active, result, spare, flags, irq_en) are 0; FSM goes to IDLE; all outputs are 0. Reset overrides ena.
- Address map:
  - 0: STATUS (RO). bit0 busy, bit1 done, bit2 aborted, bit3 err, other bits 0.
  - 1: CTRL (WO bits; read returns only irq_en in bit3). bit0 start, bit1 stop, bit2 clr, bit3 irq_en (stored).
  - 2: SPARE (RW).
  - 3: reserved; reads 0, writes ignored.
  - 4+k*NB+j: operand k, byte j (little-endian, bits [j*REG_WIDTH +: REG_WIDTH]). k: 0=P, 1=E, 2=M, 3=CONST, all RW shadow; 4=C, RO result.
  - Unmapped or RO addresses: reads return 0 (RO registers return their value); writes ignored.
- Writes take effect at the clock edge where reg_wvld=1 and ena=1. Shadow writes are allowed in any state and never disturb the active registers.
- FSM states: IDLE, BUSY.
- IDLE:
  - A CTRL write with start=1 loads active<=shadow for all four operands at that edge, registers rsa_start_cmd=1 for the next cycle only, and moves to BUSY.
  - A start write also clears done, aborted and err.
  - In IDLE, stop is ignored and eoc is ignored.
  - start=1 and stop=1 in the same write is treated as start only.
- BUSY:
  - eoc=1: capture result<=rsa_c, set done, go to IDLE.
  - CTRL write with stop=1: register rsa_stop_cmd=1 for one cycle, set aborted, go to IDLE; the result is unchanged.
  - CTRL write with start=1: ignored, sets err (stop in the same write is still honoured).
  - eoc and stop in the same cycle: eoc wins; result is captured, done is set, there is no stop pulse and aborted is not set.
  - eoc during the rsa_start_cmd cycle is accepted.
- busy = (state==BUSY). It is visible in STATUS from the cycle after the start write.
- clr=1 clears done, aborted and err. A clr in the same edge that sets a flag loses to the set.
- irq_en is written by every CTRL write.
- Latency: start write to rsa_start_cmd is 1 cycle; eoc to done/irq is 1 cycle.
- ena=0: no register, FSM or flag updates; rsa_start_cmd and rsa_stop_cmd are forced 0; reg_rdata is still valid.
- rst asserted mid-operation: returns to IDLE with all registers cleared; no stop pulse is issued.

Test Plan:
1. Write P bytes 0x11,0x22,0x33,0x44 (addr 4..7) -> rsa_p stays 0. Write CTRL=0x01 -> rsa_p=0x44332211 and start pulse 1 cycle later; STATUS=0x01.
2. In BUSY, rewrite P byte0=0xAA, then drive eoc with rsa_c=0xDEADBEEF -> rsa_p remains 0x44332211; addr 20..23 read EF,BE,AD,DE; STATUS=0x02; irq=1 only if irq_en was set.
3. In BUSY, write CTRL=0x02 -> one-cycle rsa_stop_cmd; STATUS=0x04; result unchanged.
4. In BUSY, write CTRL=0x01 -> no second start pulse; STATUS=0x09. Then write CTRL=0x04 after eoc -> STATUS=0x00.
5. Same cycle: eoc=1 and CTRL=0x02 write -> done=1, aborted=0, no stop pulse.
6. ena=0 during a CTRL=0x01 write -> no pulse, STATUS stays 0x00. Assert rst in BUSY -> all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/rsa_reg_bank_if.sv
// Register bus between the spireg serial slave and rsa_reg_bank.
interface rsa_reg_bank_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned REG_WIDTH  = 8
);
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [REG_WIDTH-1:0]  reg_wdata;
  logic                  reg_wvld;
  logic [REG_WIDTH-1:0]  reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_wvld, input  reg_rdata);
  modport slave  (input  reg_addr, reg_wdata, reg_wvld, output reg_rdata);
endinterface

// File: rtl/rsa_reg_bank.sv
// Double-buffered RSA operand register bank with a start/stop command FSM,
// status flags, result capture and a level interrupt.
module rsa_reg_bank #(
  parameter int unsigned REG_WIDTH     = 8,
  parameter int unsigned OPERAND_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  rsa_reg_bank_if.slave            bus,
  output logic [OPERAND_WIDTH-1:0] rsa_p,
  output logic [OPERAND_WIDTH-1:0] rsa_e,
  output logic [OPERAND_WIDTH-1:0] rsa_m,
  output logic [OPERAND_WIDTH-1:0] rsa_const,
  input  logic [OPERAND_WIDTH-1:0] rsa_c,
  input  logic                     eoc,
  output logic                     rsa_start_cmd,
  output logic                     rsa_stop_cmd,
  output logic [REG_WIDTH-1:0]     spare,
  output logic                     irq
);
  localparam int unsigned NB = OPERAND_WIDTH / REG_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state_q;
  logic [OPERAND_WIDTH-1:0] shadow_q [4];
  logic [OPERAND_WIDTH-1:0] active_q [4];
  logic [OPERAND_WIDTH-1:0] result_q;
  logic [REG_WIDTH-1:0]     spare_q;
  logic                     done_q, aborted_q, err_q, irq_en_q;
  logic                     start_q, stop_q;

  logic wr, ctrl_wr, c_start, c_stop, c_clr;

  assign wr      = bus.reg_wvld & ena;
  assign ctrl_wr = wr && (bus.reg_addr == ADDR_WIDTH'(1));
  assign c_start = bus.reg_wdata[0];
  assign c_stop  = bus.reg_wdata[1];
  assign c_clr   = bus.reg_wdata[2];

  always_ff @(posedge clk) begin
    // Command pulses last exactly one cycle and never linger across ena=0.
    start_q <= 1'b0;
    stop_q  <= 1'b0;
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      result_q  <= '0;
      spare_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      irq_en_q  <= 1'b0;
    end else if (ena) begin
      if (wr) begin
        if (bus.reg_addr == ADDR_WIDTH'(2)) spare_q <= bus.reg_wdata;
        for (int unsigned k = 0; k < 4; k++)
          for (int unsigned j = 0; j < NB; j++)
            if (bus.reg_addr == ADDR_WIDTH'(4 + k*NB + j))
              shadow_q[k][j*REG_WIDTH +: REG_WIDTH] <= bus.reg_wdata;
      end
      if (ctrl_wr) irq_en_q <= bus.reg_wdata[3];
      // Clear first so that any flag set below in the same edge wins.
      if (ctrl_wr && c_clr) begin
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
        err_q     <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (ctrl_wr && c_start) begin
            active_q  <= shadow_q;
            start_q   <= 1'b1;
            state_q   <= BUSY;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        BUSY: begin
          if (ctrl_wr && c_start) err_q <= 1'b1;
          if (eoc) begin
            result_q <= rsa_c;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else if (ctrl_wr && c_stop) begin
            stop_q    <= 1'b1;
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.reg_rdata = '0;
    if (bus.reg_addr == ADDR_WIDTH'(0))
      bus.reg_rdata = REG_WIDTH'({err_q, aborted_q, done_q, state_q == BUSY});
    else if (bus.reg_addr == ADDR_WIDTH'(1))
      bus.reg_rdata = REG_WIDTH'({irq_en_q, 3'b000});
    else if (bus.reg_addr == ADDR_WIDTH'(2))
      bus.reg_rdata = spare_q;
    for (int unsigned k = 0; k < 4; k++)
      for (int unsigned j = 0; j < NB; j++)
        if (bus.reg_addr == ADDR_WIDTH'(4 + k*NB + j))
          bus.reg_rdata = shadow_q[k][j*REG_WIDTH +: REG_WIDTH];
    for (int unsigned j = 0; j < NB; j++)
      if (bus.reg_addr == ADDR_WIDTH'(4 + 4*NB + j))
        bus.reg_rdata = result_q[j*REG_WIDTH +: REG_WIDTH];
  end

  assign rsa_p         = active_q[0];
  assign rsa_e         = active_q[1];
  assign rsa_m         = active_q[2];
  assign rsa_const     = active_q[3];
  assign rsa_start_cmd = start_q & ena;
  assign rsa_stop_cmd  = stop_q & ena;
  assign spare         = spare_q;
  assign irq           = irq_en_q & done_q;
endmodule

// File: tb/tb_rsa_reg_bank.sv
// Table-driven bench for rsa_reg_bank with a queue-based scoreboard.
module tb_rsa_reg_bank;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        eoc = 1'b0;
  logic [31:0] rsa_c = '0;
  logic [31:0] rsa_p, rsa_e, rsa_m, rsa_const;
  logic        rsa_start_cmd, rsa_stop_cmd, irq;
  logic [7:0]  spare;

  always #5 clk = ~clk;

  rsa_reg_bank_if #(.ADDR_WIDTH(5), .REG_WIDTH(8)) bus ();

  rsa_reg_bank #(.REG_WIDTH(8), .OPERAND_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .ena(ena), .bus(bus),
    .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m), .rsa_const(rsa_const),
    .rsa_c(rsa_c), .eoc(eoc),
    .rsa_start_cmd(rsa_start_cmd), .rsa_stop_cmd(rsa_stop_cmd),
    .spare(spare), .irq(irq)
  );

  typedef struct {
    int          tag;
    logic        rst, ena, wvld;
    logic [4:0]  addr;
    logic [7:0]  wdata;
    logic        eoc;
    logic [31:0] c;
    logic [7:0]  x_rd;
    logic        x_start, x_stop, x_irq;
    logic [31:0] x_p;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mkv(int tag, logic r, logic en, logic wv, logic [4:0] a,
                               logic [7:0] d, logic eo, logic [31:0] c, logic [7:0] rd,
                               logic st, logic sp, logic iq, logic [31:0] p);
    vec_t v;
    v.tag = tag; v.rst = r; v.ena = en; v.wvld = wv; v.addr = a; v.wdata = d;
    v.eoc = eo; v.c = c; v.x_rd = rd; v.x_start = st; v.x_stop = sp; v.x_irq = iq;
    v.x_p = p;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", name, got, want);
    end
  endtask

  // Drive one cycle of stimulus; the expectation is queued and compared after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    logic [42:0] got, want;
    @(negedge clk);
    rst = v.rst; ena = v.ena; bus.reg_wvld = v.wvld; bus.reg_addr = v.addr;
    bus.reg_wdata = v.wdata; eoc = v.eoc; rsa_c = v.c;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e    = exp_q.pop_front();
    got  = {bus.reg_rdata, rsa_start_cmd, rsa_stop_cmd, irq, rsa_p};
    want = {e.x_rd, e.x_start, e.x_stop, e.x_irq, e.x_p};
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL vec%0d: got rd=%02h st=%b sp=%b irq=%b p=%08h expected rd=%02h st=%b sp=%b irq=%b p=%08h",
               e.tag, got[42:35], got[34], got[33], got[32], got[31:0],
               want[42:35], want[34], want[33], want[32], want[31:0]);
    end
  endtask

  localparam logic [31:0] P1 = 32'h44332211;
  localparam logic [31:0] P2 = 32'h443322AA;

  initial begin
    bus.reg_addr = '0; bus.reg_wdata = '0; bus.reg_wvld = 1'b0;

    //            tag rst en wv addr  data   eoc c             rd     st sp iq p
    tbl.push_back(mkv( 0, 1, 0, 0, 5'd0,  8'h00, 0, 32'h0,        8'h00, 0, 0, 0, 32'h0));
    tbl.push_back(mkv( 1, 0, 1, 1, 5'd4,  8'h11, 0, 32'h0,        8'h11, 0, 0, 0, 32'h0));
    tbl.push_back(mkv( 2, 0, 1, 1, 5'd5,  8'h22, 0, 32'h0,        8'h22, 0, 0, 0, 32'h0));
    tbl.push_back(mkv( 3, 0, 1, 1, 5'd6,  8'h33, 0, 32'h0,        8'h33, 0, 0, 0, 32'h0));
    tbl.push_back(mkv( 4, 0, 1, 1, 5'd7,  8'h44, 0, 32'h0,        8'h44, 0, 0, 0, 32'h0));
    tbl.push_back(mkv( 5, 0, 1, 1, 5'd1,  8'h09, 0, 32'h0,        8'h08, 1, 0, 0, P1));
    tbl.push_back(mkv( 6, 0, 1, 0, 5'd0,  8'h00, 0, 32'h0,        8'h01, 0, 0, 0, P1));
    tbl.push_back(mkv( 7, 0, 1, 1, 5'd4,  8'hAA, 0, 32'h0,        8'hAA, 0, 0, 0, P1));
    tbl.push_back(mkv( 8, 0, 1, 0, 5'd0,  8'h00, 1, 32'hDEADBEEF, 8'h02, 0, 0, 1, P1));
    tbl.push_back(mkv( 9, 0, 1, 0, 5'd20, 8'h00, 0, 32'h0,        8'hEF, 0, 0, 1, P1));
    tbl.push_back(mkv(10, 0, 1, 0, 5'd21, 8'h00, 0, 32'h0,        8'hBE, 0, 0, 1, P1));
    tbl.push_back(mkv(11, 0, 1, 0, 5'd23, 8'h00, 0, 32'h0,        8'hDE, 0, 0, 1, P1));
    tbl.push_back(mkv(12, 0, 1, 0, 5'd4,  8'h00, 0, 32'h0,        8'hAA, 0, 0, 1, P1));
    tbl.push_back(mkv(13, 0, 1, 1, 5'd1,  8'h01, 0, 32'h0,        8'h00, 1, 0, 0, P2));
    tbl.push_back(mkv(14, 0, 1, 1, 5'd1,  8'h02, 0, 32'h0,        8'h00, 0, 1, 0, P2));
    tbl.push_back(mkv(15, 0, 1, 0, 5'd0,  8'h00, 0, 32'h0,        8'h04, 0, 0, 0, P2));
    tbl.push_back(mkv(16, 0, 1, 0, 5'd20, 8'h00, 0, 32'h0,        8'hEF, 0, 0, 0, P2));
    tbl.push_back(mkv(17, 0, 1, 1, 5'd1,  8'h02, 0, 32'h0,        8'h00, 0, 0, 0, P2));
    tbl.push_back(mkv(18, 0, 1, 0, 5'd0,  8'h00, 0, 32'h0,        8'h04, 0, 0, 0, P2));
    tbl.push_back(mkv(19, 0, 1, 1, 5'd1,  8'h01, 0, 32'h0,        8'h00, 1, 0, 0, P2));
    tbl.push_back(mkv(20, 0, 1, 1, 5'd1,  8'h01, 0, 32'h0,        8'h00, 0, 0, 0, P2));
    tbl.push_back(mkv(21, 0, 1, 0, 5'd0,  8'h00, 0, 32'h0,        8'h09, 0, 0, 0, P2));
    tbl.push_back(mkv(22, 0, 1, 0, 5'd0,  8'h00, 1, 32'h12345678, 8'h0A, 0, 0, 0, P2));
    tbl.push_back(mkv(23, 0, 1, 1, 5'd1,  8'h04, 0, 32'h0,        8'h00, 0, 0, 0, P2));
    tbl.push_back(mkv(24, 0, 1, 0, 5'd0,  8'h00, 0, 32'h0,        8'h00, 0, 0, 0, P2));
    tbl.push_back(mkv(25, 0, 1, 0, 5'd20, 8'h00, 0, 32'h0,        8'h78, 0, 0, 0, P2));
    tbl.push_back(mkv(26, 0, 1, 1, 5'd1,  8'h01, 0, 32'h0,        8'h00, 1, 0, 0, P2));
    tbl.push_back(mkv(27, 0, 1, 1, 5'd1,  8'h02, 1, 32'hCAFEF00D, 8'h00, 0, 0, 0, P2));
    tbl.push_back(mkv(28, 0, 1, 0, 5'd0,  8'h00, 0, 32'h0,        8'h02, 0, 0, 0, P2));
    tbl.push_back(mkv(29, 0, 1, 0, 5'd22, 8'h00, 0, 32'h0,        8'hFE, 0, 0, 0, P2));
    tbl.push_back(mkv(30, 0, 1, 1, 5'd1,  8'h04, 0, 32'h0,        8'h00, 0, 0, 0, P2));
    tbl.push_back(mkv(31, 0, 0, 1, 5'd1,  8'h01, 0, 32'h0,        8'h00, 0, 0, 0, P2));
    tbl.push_back(mkv(32, 0, 1, 0, 5'd0,  8'h00, 0, 32'h0,        8'h00, 0, 0, 0, P2));
    tbl.push_back(mkv(33, 0, 1, 1, 5'd1,  8'h01, 0, 32'h0,        8'h00, 1, 0, 0, P2));
    tbl.push_back(mkv(34, 1, 1, 0, 5'd0,  8'h00, 0, 32'h0,        8'h00, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(35, 0, 1, 0, 5'd4,  8'h00, 0, 32'h0,        8'h00, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(36, 0, 1, 0, 5'd20, 8'h00, 0, 32'h0,        8'h00, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(37, 0, 1, 1, 5'd1,  8'h01, 0, 32'h0,        8'h00, 1, 0, 0, 32'h0));
    tbl.push_back(mkv(38, 0, 1, 0, 5'd0,  8'h00, 1, 32'h55AA55AA, 8'h02, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(39, 0, 1, 0, 5'd21, 8'h00, 0, 32'h0,        8'h55, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(40, 0, 1, 1, 5'd1,  8'h01, 0, 32'h0,        8'h00, 1, 0, 0, 32'h0));
    tbl.push_back(mkv(41, 0, 1, 1, 5'd1,  8'h05, 0, 32'h0,        8'h00, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(42, 0, 1, 0, 5'd0,  8'h00, 0, 32'h0,        8'h09, 0, 0, 0, 32'h0));
    tbl.push_back(mkv(43, 0, 1, 0, 5'd0,  8'h00, 1, 32'h13572468, 8'h0A, 0, 0, 0, 32'h0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Spare, reserved, unmapped and read-only result addresses.
    apply(mkv(100, 0, 1, 1, 5'd2,  8'h5C, 0, 32'h0, 8'h5C, 0, 0, 0, 32'h0));
    check32("spare_out", {24'h0, spare}, 32'h0000005C);
    apply(mkv(101, 0, 1, 1, 5'd3,  8'hFF, 0, 32'h0, 8'h00, 0, 0, 0, 32'h0));
    apply(mkv(102, 0, 1, 1, 5'd24, 8'h77, 0, 32'h0, 8'h00, 0, 0, 0, 32'h0));
    apply(mkv(103, 0, 1, 0, 5'd31, 8'h00, 0, 32'h0, 8'h00, 0, 0, 0, 32'h0));
    apply(mkv(104, 0, 1, 1, 5'd20, 8'h00, 0, 32'h0, 8'h68, 0, 0, 0, 32'h0));

    // Load E, M and CONST shadows, then start and confirm the active copies.
    for (int j = 0; j < 4; j++) begin
      apply(mkv(110 + j, 0, 1, 1, 5'(8 + j),  8'(1 + j), 0, 32'h0, 8'(1 + j), 0, 0, 0, 32'h0));
      apply(mkv(120 + j, 0, 1, 1, 5'(12 + j), 8'(5 + j), 0, 32'h0, 8'(5 + j), 0, 0, 0, 32'h0));
      apply(mkv(130 + j, 0, 1, 1, 5'(16 + j), 8'(9 + j), 0, 32'h0, 8'(9 + j), 0, 0, 0, 32'h0));
    end
    check32("e_before_start", rsa_e, 32'h0);
    apply(mkv(140, 0, 1, 1, 5'd1, 8'h01, 0, 32'h0, 8'h00, 1, 0, 0, 32'h0));
    check32("e_active", rsa_e, 32'h04030201);
    check32("m_active", rsa_m, 32'h08070605);
    check32("const_active", rsa_const, 32'h0C0B0A09);
    apply(mkv(141, 0, 1, 0, 5'd0, 8'h00, 1, 32'h0, 8'h02, 0, 0, 0, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
